lvds_adc_tx_emulator: RTL
=========================

Name: lvds_adc_tx_emulator

Overview:
- Bit-serial LVDS ADC transmitter model that drives the same 8-lane, 12-bit, MSB-first serial format the ADC capture path receives.
- It generates bit_clk, frame_clk and per-lane serial data from a single fabric clock, one serial bit per clk.
- It is used for loopback self-test of the capture/deskew path and for bench bring-up without the ADC populated.
- Sample source is either an external parallel stream (valid/ready) or an internal test-pattern generator.

Parameters:
NLANES, 8, number of serial data lanes
NBITS, 12, bits per sample per lane (frame length in clk cycles)

Ports:
clk  input  1  fabric clock, one serial bit per cycle (bit_clk = clk/2, DDR)
reset_n  input  1  synchronous active-low reset
tx_enable  input  1  1 = transmit frames; 0 = idle, outputs held low
pattern_sel  input  3  source select, sampled only at load cycles
custom_pattern  input  NBITS  constant word for pattern_sel=5, sampled at load cycles
sample_in  input  NLANES*NBITS  lane i occupies bits [i*NBITS +: NBITS]
sample_valid  input  1  sample_in holds a valid word set
sample_ready  output  1  load cycle in external mode; transfer when valid&ready
lvds_out  output  NLANES  serial data, MSB first
bit_clk_out  output  1  serial bit clock
frame_clk_out  output  1  frame clock, high for first NBITS/2 bits
frame_start  output  1  one-cycle pulse coincident with bit 0 of each frame
underrun_count  output  16  saturating count of load cycles in external mode with no valid sample

Behaviour:
- Synchronous active-low reset on clk: bit_cnt=NBITS-1, idle=1, shift regs=0, ramp=0, toggle phase=0 (next word 0xAAA), last_sample=0, underrun_count=0.
- Reset values of all outputs: lvds_out=0, bit_clk_out=0, frame_clk_out=0, frame_start=0, sample_ready=0.
- Reset mid-frame aborts immediately; no partial-frame completion.
- Disabled (tx_enable=0): bit_cnt held at NBITS-1, all outputs low. sample_ready=0. Deassertion takes effect on the next clk, including mid-frame.
- Load cycle: any cycle with tx_enable=1 and bit_cnt=NBITS-1. This includes the first enabled cycle after idle, during which outputs are still low.
- At the end of a load cycle:
  - pattern_sel and custom_pattern are captured.
  - The next word per lane is loaded into the shift regs.
  - bit_cnt wraps to 0.
- Frame cycle with bit_cnt=k, 0..NBITS-1. All outputs are register outputs aligned to bit_cnt:
  - lvds_out[i] = bit NBITS-1-k of the current word of lane i.
  - frame_clk_out = (k < NBITS/2).
  - bit_clk_out = (k even).
  - frame_start = (k==0).
- Latency: a word accepted in the load cycle has its MSB on lvds_out in the following cycle (k=0). Frames are back-to-back with no gap; the k=NBITS-1 cycle of one frame is the load cycle of the next.
- pattern_sel sources. A change of pattern_sel mid-frame is ignored until the next load cycle.
  - 0 = external.
  - 1 = 0x000 all lanes.
  - 2 = 0xFFF.
  - 3 = toggle: 0xAAA and 0x555 on alternate frames, starting with 0xAAA.
  - 4 = ramp: lane i sends (ramp+i) mod 2^NBITS; ramp increments by 1 per frame, 0xFFF wraps to 0x000.
  - 5 = custom_pattern on all lanes.
  - 6 = deskew 0xFC0.
  - 7 = reserved, sends 0x000.
- Ramp and toggle state advance only while their pattern is selected. They are not reset on pattern change, only by reset_n.
- External mode handshake:
  - sample_ready=1 exactly in load cycles, otherwise 0.
  - valid&ready: sample_in is loaded and copied into last_sample.
  - ready&!valid: last_sample is retransmitted and underrun_count increments, saturating at 0xFFFF.
  - sample_valid outside load cycles is ignored; no buffering.
- tx_enable rising: the first enabled cycle is a load cycle, and bit 0 follows one cycle later.

Test Plan:
- Reset, tx_enable=1, pattern_sel=5, custom=0xA5C -> after the first load cycle lane 0 shows 1,0,1,0,0,1,0,1,1,1,0,0. frame_clk_out high 6 cycles, low 6. frame_start pulses every 12 cycles. bit_clk_out toggles each cycle.
- pattern_sel=4 for 4 frames -> lane 0 words 0x000,0x001,0x002,0x003 and lane 7 words 0x007..0x00A. Force ramp near wrap: 0xFFE,0xFFF,0x000.
- External mode, valid held high with a new word each load cycle (0x123 lane 0) -> MSB appears the cycle after sample_ready, underrun_count=0. Drop valid for 3 load cycles -> last word repeated 3 times, underrun_count=3.
- Switch pattern_sel 3→2 at k=5 -> current toggle frame completes unchanged, the next frame is 0xFFF. Switch back -> toggle resumes with the opposite phase.
- tx_enable low at k=7 -> lvds_out, bit_clk_out and frame_clk_out are 0 on the next cycle. Re-enable -> one load cycle with outputs low, then bit 0.
- reset_n low for 1 cycle mid-frame -> all outputs 0 and underrun_count=0 the next cycle. Ramp restarts at 0x000.

Source files
------------

// File: rtl/lvds_adc_tx_emulator_if.sv
// Parallel sample stream into the LVDS ADC transmitter emulator.
// The source drives one word per lane; the emulator accepts it on valid & ready.
interface lvds_adc_tx_emulator_if #(
  parameter int NLANES = 8,
  parameter int NBITS  = 12
);
  logic [NLANES*NBITS-1:0] sample;
  logic                    valid;
  logic                    ready;

  modport master (output sample, output valid, input ready);
  modport slave  (input sample, input valid, output ready);
endinterface

// File: rtl/lvds_adc_tx_emulator.sv
// Bit-serial LVDS ADC transmitter model: NLANES lanes of NBITS-bit MSB-first frames,
// with bit/frame clocks, sourced from an external stream or a built-in pattern generator.
module lvds_adc_tx_emulator #(
  parameter int NLANES = 8,
  parameter int NBITS  = 12
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 tx_enable_i,
  input  logic [2:0]           pattern_sel_i,
  input  logic [NBITS-1:0]     custom_pattern_i,
  lvds_adc_tx_emulator_if.slave smp_if,
  output logic [NLANES-1:0]    lvds_out_o,
  output logic                 bit_clk_out_o,
  output logic                 frame_clk_out_o,
  output logic                 frame_start_o,
  output logic [15:0]          underrun_count_o
);

  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0] HALF = CW'(NBITS / 2);
  localparam logic [NBITS-1:0] TOGGLE_A = {(NBITS/2){2'b10}};
  localparam logic [NBITS-1:0] DESKEW   = {{(NBITS/2){1'b1}}, {(NBITS-NBITS/2){1'b0}}};

  // Bits remaining in the current frame: NBITS-1-k. Zero marks the load cycle.
  logic [CW-1:0]     rem_q, rem_d;
  logic [NBITS-1:0]  word_q [NLANES];
  logic [NBITS-1:0]  word_d [NLANES];
  logic [NBITS-1:0]  cur_d  [NLANES];
  logic [NBITS-1:0]  last_q [NLANES];
  logic [NBITS-1:0]  ramp_q;
  logic              toggle_q;
  logic [15:0]       underrun_q;
  logic [NLANES-1:0] lvds_q, lvds_d;
  logic              bit_clk_q, frame_clk_q, frame_start_q;
  logic              load, ext_load;

  assign load     = tx_enable_i && (rem_q == '0);
  assign ext_load = load && (pattern_sel_i == 3'd0);
  assign rem_d    = load ? LAST : rem_q - 1'b1;

  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      word_d[i] = '0;
      case (pattern_sel_i)
        3'd0: word_d[i] = smp_if.valid ? smp_if.sample[i*NBITS +: NBITS] : last_q[i];
        3'd1: word_d[i] = '0;
        3'd2: word_d[i] = '1;
        3'd3: word_d[i] = toggle_q ? ~TOGGLE_A : TOGGLE_A;
        3'd4: word_d[i] = ramp_q + NBITS'(i);
        3'd5: word_d[i] = custom_pattern_i;
        3'd6: word_d[i] = DESKEW;
        default: word_d[i] = '0;
      endcase
      cur_d[i]  = load ? word_d[i] : word_q[i];
      lvds_d[i] = cur_d[i][rem_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rem_q         <= '0;
      ramp_q        <= '0;
      toggle_q      <= 1'b0;
      underrun_q    <= '0;
      lvds_q        <= '0;
      bit_clk_q     <= 1'b0;
      frame_clk_q   <= 1'b0;
      frame_start_q <= 1'b0;
      for (int i = 0; i < NLANES; i++) begin
        word_q[i] <= '0;
        last_q[i] <= '0;
      end
    end else if (!tx_enable_i) begin
      rem_q         <= '0;
      lvds_q        <= '0;
      bit_clk_q     <= 1'b0;
      frame_clk_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      rem_q         <= rem_d;
      lvds_q        <= lvds_d;
      frame_clk_q   <= (rem_d >= HALF);
      bit_clk_q     <= (rem_d[0] == LAST[0]);
      frame_start_q <= (rem_d == LAST);
      if (load) begin
        for (int i = 0; i < NLANES; i++) word_q[i] <= word_d[i];
        if (pattern_sel_i == 3'd3) toggle_q <= ~toggle_q;
        if (pattern_sel_i == 3'd4) ramp_q <= ramp_q + 1'b1;
      end
      // Without a valid word the previous one is resent and the miss is counted.
      if (ext_load) begin
        if (smp_if.valid) begin
          for (int i = 0; i < NLANES; i++) last_q[i] <= smp_if.sample[i*NBITS +: NBITS];
        end else if (underrun_q != '1) begin
          underrun_q <= underrun_q + 16'd1;
        end
      end
    end
  end

  assign smp_if.ready     = reset_n_i && ext_load;
  assign lvds_out_o       = lvds_q;
  assign bit_clk_out_o    = bit_clk_q;
  assign frame_clk_out_o  = frame_clk_q;
  assign frame_start_o    = frame_start_q;
  assign underrun_count_o = underrun_q;

endmodule
